writeback_arbiter: RTL and testbench

Collects completed results from the execution flows and serialises them onto the single register-bank write port. For each written physical register it also broadcasts a wakeup, so the scheduler's operand-ready view is restored after rename invalidated it. It sits between the flow units and the `regbank` write port, at the opposite end of the issue path from the scheduler.

---
 rtl/writeback_arbiter.sv | 139 +++++++++++++
 tb/tb_writeback_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Result writeback arbiter: per-source FIFOs, round-robin onto one register-bank write port,
// with a wakeup broadcast mirroring every committed write.
module writeback_arbiter #(
  parameter int unsigned PORTS  = 2,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 7,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PORTS-1:0][DWIDTH-1:0]   result_data_i,
  input  logic [PORTS-1:0][AWIDTH-1:0]   result_addr_i,
  input  logic [PORTS-1:0]               result_valid_i,
  output logic [PORTS-1:0]               result_ready_o,
  input  logic                           flush,
  output logic [DWIDTH-1:0]              write_data,
  output logic [AWIDTH-1:0]              write_address,
  output logic                           write_enable,
  output logic [AWIDTH-1:0]              wakeup_addr,
  output logic                           wakeup_valid,
  output logic                           busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } entry_t;

  entry_t           mem [PORTS][DEPTH];
  logic [CW-1:0]    count [PORTS];
  logic [PW-1:0]    rd_ptr [PORTS];
  logic [PW-1:0]    wr_ptr [PORTS];
  entry_t           head_c [PORTS];

  logic [PORTS-1:0] nonempty_c;
  logic [PORTS-1:0] push_c;
  logic [PORTS-1:0] pop_c;

  logic [SW-1:0]    rr_ptr;
  logic [SW-1:0]    rr_next_c;
  logic [SW-1:0]    grant_idx_c;
  logic             grant_valid_c;
  entry_t           grant_entry_c;

  // Pointer advance modulo DEPTH (also correct for DEPTH == 1).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  for (genvar gi = 0; gi < int'(PORTS); gi++) begin : g_fifo
    // Ready looks only at the registered count, never at this cycle's pop.
    assign result_ready_o[gi] = (count[gi] != CW'(DEPTH)) & reset;
    assign nonempty_c[gi]     = (count[gi] != '0);
    assign push_c[gi]         = result_valid_i[gi] & result_ready_o[gi] & ~flush;
    assign pop_c[gi]          = grant_valid_c & (grant_idx_c == SW'(gi));
    assign head_c[gi]         = mem[gi][rd_ptr[gi]];

    always_ff @(posedge clk) begin
      if (push_c[gi]) begin
        mem[gi][wr_ptr[gi]] <= {result_addr_i[gi], result_data_i[gi]};
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        count[gi]  <= '0;
        rd_ptr[gi] <= '0;
        wr_ptr[gi] <= '0;
      end else if (flush) begin
        count[gi]  <= '0;
        rd_ptr[gi] <= '0;
        wr_ptr[gi] <= '0;
      end else begin
        if (push_c[gi]) wr_ptr[gi] <= ptr_inc(wr_ptr[gi]);
        if (pop_c[gi])  rd_ptr[gi] <= ptr_inc(rd_ptr[gi]);
        case ({push_c[gi], pop_c[gi]})
          2'b10:   count[gi] <= count[gi] + CW'(1);
          2'b01:   count[gi] <= count[gi] - CW'(1);
          default: count[gi] <= count[gi];
        endcase
      end
    end
  end

  // Round-robin pick: lowest non-empty index >= rr_ptr, else lowest below it.
  always_comb begin
    grant_valid_c = 1'b0;
    grant_idx_c   = '0;
    for (int j = int'(PORTS) - 1; j >= 0; j--) begin
      if (nonempty_c[SW'(j)] && (SW'(j) < rr_ptr)) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = SW'(j);
      end
    end
    for (int j = int'(PORTS) - 1; j >= 0; j--) begin
      if (nonempty_c[SW'(j)] && (SW'(j) >= rr_ptr)) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = SW'(j);
      end
    end
    if (flush) grant_valid_c = 1'b0;
  end

  assign grant_entry_c = head_c[grant_idx_c];
  assign rr_next_c     = (grant_idx_c == SW'(PORTS - 1)) ? '0 : grant_idx_c + SW'(1);

  // Write-port register; address 0 consumes a grant but never writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr        <= '0;
      write_enable  <= 1'b0;
      write_data    <= '0;
      write_address <= '0;
    end else if (flush) begin
      rr_ptr       <= '0;
      write_enable <= 1'b0;
    end else if (grant_valid_c) begin
      rr_ptr <= rr_next_c;
      if (grant_entry_c.addr != '0) begin
        write_enable  <= 1'b1;
        write_data    <= grant_entry_c.data;
        write_address <= grant_entry_c.addr;
      end else begin
        write_enable <= 1'b0;
      end
    end else begin
      write_enable <= 1'b0;
    end
  end

  assign wakeup_addr  = write_address;
  assign wakeup_valid = write_enable;
  assign busy         = (|nonempty_c) | write_enable;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected writes are queued up front and a
// negedge monitor pops and compares every write the DUT makes.
module tb_writeback_arbiter;

  localparam int unsigned PORTS = 2;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 7;
  localparam int unsigned DEPTH = 2;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic [PORTS-1:0][DW-1:0]   result_data_i = '0;
  logic [PORTS-1:0][AW-1:0]   result_addr_i = '0;
  logic [PORTS-1:0]           result_valid_i = '0;
  logic [PORTS-1:0]           result_ready_o;
  logic                       flush = 1'b0;
  logic [DW-1:0]              write_data;
  logic [AW-1:0]              write_address;
  logic                       write_enable;
  logic [AW-1:0]              wakeup_addr;
  logic                       wakeup_valid;
  logic                       busy;

  writeback_arbiter #(.PORTS(PORTS), .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .result_data_i(result_data_i), .result_addr_i(result_addr_i),
    .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
    .flush(flush),
    .write_data(write_data), .write_address(write_address), .write_enable(write_enable),
    .wakeup_addr(wakeup_addr), .wakeup_valid(wakeup_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sb.push_back({a, d});
  endtask

  // Offer one result; called and returns at posedge+1. Ready is sampled at the negedge before.
  task automatic send(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic r;
    int   n;
    n = 0;
    result_valid_i[s] = 1'b1;
    result_addr_i[s]  = a;
    result_data_i[s]  = d;
    forever begin
      @(negedge clk);
      r = result_ready_o[s];
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 100) begin
        total++;
        bad++;
        $display("FAIL send_timeout src%0d addr %0d: ready never high, want accept", s, a);
        break;
      end
    end
    result_valid_i[s] = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      // Monitor: every write must match the next queued expectation.
      forever begin
        @(negedge clk);
        if (write_enable === 1'b1) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %0d data %0h, want no write", write_address, write_data);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wr_addr", 64'(write_address), 64'(e.a));
            chk("wr_data", 64'(write_data), 64'(e.d));
            chk("wakeup_addr", 64'(wakeup_addr), 64'(e.a));
            chk("wakeup_valid", 64'(wakeup_valid), 64'd1);
          end
        end else begin
          chk("wakeup_idle", 64'(wakeup_valid), 64'd0);
        end
      end
    join_none

    // Reset state
    #1;
    chk("rst_we", 64'(write_enable), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wdata", 64'(write_data), 64'd0);
    chk("rst_waddr", 64'(write_address), 64'd0);
    chk("rst_ready", 64'(result_ready_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ready_after_rst", 64'(result_ready_o), 64'h3);
    @(posedge clk);
    #1;

    // Single result, 2-edge latency
    expect_wr(7'd5, 32'h1234);
    fork
      send(0, 7'd5, 32'h1234);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("single_e1_we", 64'(write_enable), 64'd0);
        @(negedge clk);
        chk("single_e2_we", 64'(write_enable), 64'd1);
        chk("single_e2_addr", 64'(write_address), 64'd5);
      end
    join
    drain();

    // Contention: strict alternation, no idle write cycles
    do_flush();
    foreach (sb[i]) sb.delete(i);
    expect_wr(7'd10, 32'hA10); expect_wr(7'd20, 32'hB20);
    expect_wr(7'd11, 32'hA11); expect_wr(7'd21, 32'hB21);
    expect_wr(7'd12, 32'hA12); expect_wr(7'd22, 32'hB22);
    fork
      begin send(0, 7'd10, 32'hA10); send(0, 7'd11, 32'hA11); send(0, 7'd12, 32'hA12); end
      begin send(1, 7'd20, 32'hB20); send(1, 7'd21, 32'hB21); send(1, 7'd22, 32'hB22); end
      begin
        repeat (2) @(posedge clk);
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          chk("contend_back2back_we", 64'(write_enable), 64'd1);
        end
      end
    join
    drain();

    // Backpressure: source 1 fills its 2-entry FIFO, ready drops then recovers
    do_flush();
    expect_wr(7'd40, 32'hC40); expect_wr(7'd50, 32'hD50);
    expect_wr(7'd41, 32'hC41); expect_wr(7'd51, 32'hD51);
    expect_wr(7'd42, 32'hC42); expect_wr(7'd52, 32'hD52);
    expect_wr(7'd43, 32'hC43);
    fork
      begin
        send(0, 7'd40, 32'hC40); send(0, 7'd41, 32'hC41);
        send(0, 7'd42, 32'hC42); send(0, 7'd43, 32'hC43);
      end
      begin send(1, 7'd50, 32'hD50); send(1, 7'd51, 32'hD51); send(1, 7'd52, 32'hD52); end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_ready1_full", 64'(result_ready_o[1]), 64'd0);
        @(negedge clk);
        chk("bp_ready1_recover", 64'(result_ready_o[1]), 64'd1);
      end
    join
    drain();

    // Register 0 is swallowed but still costs a grant slot
    do_flush();
    expect_wr(7'd7, 32'h77);
    fork
      begin send(0, 7'd0, 32'hDEAD); send(0, 7'd7, 32'h77); end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("r0_slot_we", 64'(write_enable), 64'd0);
        chk("r0_slot_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("r0_next_we", 64'(write_enable), 64'd1);
      end
    join
    drain();

    // Flush: only the one already-granted entry is written
    do_flush();
    expect_wr(7'd30, 32'hE30);
    fork
      begin send(0, 7'd30, 32'hE30); send(0, 7'd31, 32'hE31); end
      begin send(1, 7'd35, 32'hF35); send(1, 7'd36, 32'hF36); end
    join
    flush = 1'b1;
    result_valid_i[0] = 1'b1;
    result_addr_i[0]  = 7'd9;
    result_data_i[0]  = 32'h999;
    @(posedge clk);
    #1;
    flush = 1'b0;
    result_valid_i[0] = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_we", 64'(write_enable), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    expect_wr(7'd37, 32'h337);
    fork
      send(1, 7'd37, 32'h337);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("postflush_e1_we", 64'(write_enable), 64'd0);
        @(negedge clk);
        chk("postflush_e2_we", 64'(write_enable), 64'd1);
        chk("postflush_e2_addr", 64'(write_address), 64'd37);
      end
    join
    drain();

    // Async reset mid-operation
    result_valid_i   = 2'b11;
    result_addr_i[0] = 7'd60;
    result_data_i[0] = 32'h600;
    result_addr_i[1] = 7'd70;
    result_data_i[1] = 32'h700;
    @(posedge clk);
    #1;
    result_valid_i = 2'b00;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_we", 64'(write_enable), 64'd0);
    chk("arst_wakeup_valid", 64'(wakeup_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_waddr", 64'(write_address), 64'd0);
    chk("arst_wdata", 64'(write_data), 64'd0);
    chk("arst_wakeup_addr", 64'(wakeup_addr), 64'd0);
    chk("arst_ready", 64'(result_ready_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("arst_ready_held", 64'(result_ready_o), 64'd0);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("post_arst_busy", 64'(busy), 64'd0);
    chk("post_arst_ready", 64'(result_ready_o), 64'h3);
    chk("post_arst_sb", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
